// File: rtl/font_rom_arbiter_if.sv
// -----------------------------------------------------------------------------
// font_rom_arbiter_if
//   Bundle of the request, ROM and read-data signals around font_rom_arbiter.
//
//   Requester side : req0/code0/row0, req1/code1/row1 in; gnt0/gnt1 back.
//   ROM side       : rom_ascii (registered address) out; rom_letra (glyph,
//                    combinational from rom_ascii) back.
//   Read side      : rd_valid, rd_owner, rd_bits, rd_err.
//
//   Modports:
//     slave  - the arbiter itself
//     master - the two requesters / read-data consumers
//     rom    - the font ROM instance
//
//   rom_letra is indexed as rom_letra[row][col]; each row is COLS bits with
//   the MSB being the leftmost pixel.
// -----------------------------------------------------------------------------
interface font_rom_arbiter_if #(
    parameter int unsigned CODE_W = 9,
    parameter int unsigned ROWS   = 10,
    parameter int unsigned COLS   = 10
);
    logic                         req0;
    logic [CODE_W-1:0]            code0;
    logic [3:0]                   row0;
    logic                         req1;
    logic [CODE_W-1:0]            code1;
    logic [3:0]                   row1;
    logic                         gnt0;
    logic                         gnt1;
    logic [CODE_W-1:0]            rom_ascii;
    logic [ROWS-1:0][COLS-1:0]    rom_letra;
    logic                         rd_valid;
    logic                         rd_owner;
    logic [COLS-1:0]              rd_bits;
    logic                         rd_err;

    modport slave (
        input  req0, code0, row0, req1, code1, row1, rom_letra,
        output gnt0, gnt1, rom_ascii, rd_valid, rd_owner, rd_bits, rd_err
    );

    modport master (
        output req0, code0, row0, req1, code1, row1,
        input  gnt0, gnt1, rd_valid, rd_owner, rd_bits, rd_err
    );

    modport rom (
        input  rom_ascii,
        output rom_letra
    );
endinterface

// File: rtl/font_rom_arbiter.sv
// -----------------------------------------------------------------------------
// font_rom_arbiter
//   Shares one combinational font glyph ROM between two requesters.
//   Port 0 (VGA text scan-out) has priority; port 1 (secondary glyph consumer)
//   is guaranteed a slot after MAX_WAIT consecutive port-0 wins while it waits.
//   One lookup per cycle, fixed latency: grant and ROM address at edge N,
//   selected glyph row at edge N+1.
//
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - font_rom_arbiter_if.slave: requests, grants, ROM address/data,
//             read-data outputs (rd_valid/rd_owner/rd_bits/rd_err)
// -----------------------------------------------------------------------------
module font_rom_arbiter #(
    parameter int unsigned CODE_W     = 9,
    parameter int unsigned NUM_GLYPHS = 200,
    parameter int unsigned ROWS       = 10,
    parameter int unsigned COLS       = 10,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    font_rom_arbiter_if.slave  bus
);
    localparam int unsigned ROW_W = 4;
    localparam int unsigned CNT_W = 3;

    // Limits widened by one bit so the range compare cannot wrap.
    localparam logic [CODE_W:0]    CODE_LIM = (CODE_W + 1)'(NUM_GLYPHS);
    localparam logic [ROW_W:0]     ROW_LIM  = (ROW_W + 1)'(ROWS);
    localparam logic [CNT_W-1:0]   WAIT_LIM = CNT_W'(MAX_WAIT);

    // Arbitration state
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;

    // Stage 1: captured winner
    logic [CODE_W-1:0] rom_ascii_q, rom_ascii_d;
    logic [ROW_W-1:0]  row_s1_q, row_s1_d;
    logic              own_s1_q, own_s1_d;
    logic              err_s1_q, err_s1_d;
    logic              v_s1_q, v_s1_d;

    // Stage 2: read data
    logic              rd_valid_q, rd_valid_d;
    logic              rd_owner_q, rd_owner_d;
    logic [COLS-1:0]   rd_bits_q, rd_bits_d;
    logic              rd_err_q, rd_err_d;

    // Combinational helpers
    logic              force1;
    logic              take0;
    logic              take1;
    logic [CODE_W-1:0] win_code;
    logic [ROW_W-1:0]  win_row;
    logic              win_err;
    logic [COLS-1:0]   row_bits;

    always_comb begin
        force1   = 1'b0;
        take0    = 1'b0;
        take1    = 1'b0;
        win_code = '0;
        win_row  = '0;
        win_err  = 1'b0;
        row_bits = '0;

        starve_d    = starve_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rom_ascii_d = rom_ascii_q;
        row_s1_d    = row_s1_q;
        own_s1_d    = own_s1_q;
        err_s1_d    = err_s1_q;
        v_s1_d      = 1'b0;

        // Port 0 wins ties unless port 1 has already waited MAX_WAIT grants.
        force1 = bus.req0 && bus.req1 && (starve_q == WAIT_LIM);
        take0  = bus.req0 && !force1;
        take1  = bus.req1 && !take0;

        win_code = take1 ? bus.code1 : bus.code0;
        win_row  = take1 ? bus.row1  : bus.row0;
        win_err  = ({1'b0, win_code} >= CODE_LIM) || ({1'b0, win_row} >= ROW_LIM);

        gnt0_d = take0;
        gnt1_d = take1;
        v_s1_d = take0 || take1;

        // Address held when idle; forced to 0 on a bad request so the ROM
        // is never addressed out of range.
        if (take0 || take1) begin
            rom_ascii_d = win_err ? '0 : win_code;
            row_s1_d    = win_row;
            own_s1_d    = take1;
            err_s1_d    = win_err;
        end

        if (!bus.req1 || take1) begin
            starve_d = '0;
        end else if (take0 && (starve_q != WAIT_LIM)) begin
            starve_d = starve_q + CNT_W'(1);
        end

        // Row mux over the glyph; an out-of-range row never matches.
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (row_s1_q == ROW_W'(r)) begin
                row_bits = bus.rom_letra[r];
            end
        end

        rd_valid_d = v_s1_q;
        rd_owner_d = own_s1_q;
        rd_err_d   = v_s1_q && err_s1_q;
        rd_bits_d  = (v_s1_q && !err_s1_q) ? row_bits : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q    <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rom_ascii_q <= '0;
            row_s1_q    <= '0;
            own_s1_q    <= 1'b0;
            err_s1_q    <= 1'b0;
            v_s1_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_owner_q  <= 1'b0;
            rd_bits_q   <= '0;
            rd_err_q    <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rom_ascii_q <= rom_ascii_d;
            row_s1_q    <= row_s1_d;
            own_s1_q    <= own_s1_d;
            err_s1_q    <= err_s1_d;
            v_s1_q      <= v_s1_d;
            rd_valid_q  <= rd_valid_d;
            rd_owner_q  <= rd_owner_d;
            rd_bits_q   <= rd_bits_d;
            rd_err_q    <= rd_err_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.rom_ascii = rom_ascii_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_owner  = rd_owner_q;
    assign bus.rd_bits   = rd_bits_q;
    assign bus.rd_err    = rd_err_q;
endmodule

// File: tb/tb_font_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_font_rom_arbiter
//   Scoreboard bench for font_rom_arbiter. A driver issues requests on the
//   falling edge and predicts the winner from the arbitration rules, pushing
//   the expected read beat into a queue. A monitor samples just after each
//   rising edge, checks grants/address, and pops/compares on rd_valid.
//   A hashed function stands in for the font ROM.
// -----------------------------------------------------------------------------
module tb_font_rom_arbiter;
    localparam int unsigned CODE_W     = 9;
    localparam int unsigned NUM_GLYPHS = 200;
    localparam int unsigned ROWS       = 10;
    localparam int unsigned COLS       = 10;
    localparam int unsigned MAX_WAIT   = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    font_rom_arbiter_if #(.CODE_W(CODE_W), .ROWS(ROWS), .COLS(COLS)) bus ();

    font_rom_arbiter #(
        .CODE_W    (CODE_W),
        .NUM_GLYPHS(NUM_GLYPHS),
        .ROWS      (ROWS),
        .COLS      (COLS),
        .MAX_WAIT  (MAX_WAIT)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // Font ROM stand-in: arbitrary but deterministic row contents.
    function automatic logic [COLS-1:0] glyph_row(input int unsigned code, input int unsigned row);
        int unsigned h;
        h = code * 131 + row * 29 + 7;
        h = h ^ (h >> 5) ^ (code << 2);
        return h[COLS-1:0];
    endfunction

    always_comb begin
        for (int unsigned r = 0; r < ROWS; r++) begin
            bus.rom_letra[r] = glyph_row(32'(bus.rom_ascii), r);
        end
    end

    typedef struct {
        logic            owner;
        logic            err;
        logic [COLS-1:0] bits;
    } exp_t;

    exp_t              sb_q[$];
    int unsigned       total = 0;
    int unsigned       bad = 0;
    logic              exp_g0 = 1'b0;
    logic              exp_g1 = 1'b0;
    logic [CODE_W-1:0] exp_ascii = '0;
    bit                chk_en = 1'b0;
    int unsigned       waited = 0;
    int unsigned       g0_seen = 0;
    int unsigned       g1_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One cycle of stimulus plus reference prediction for the coming edge.
    task automatic drive(input bit r0, input int unsigned c0, input int unsigned w0,
                         input bit r1, input int unsigned c1, input int unsigned w1);
        bit          win0;
        bit          win1;
        int unsigned code;
        int unsigned row;
        exp_t        e;
        @(negedge clk);
        bus.req0  = r0;
        bus.code0 = CODE_W'(c0);
        bus.row0  = 4'(w0);
        bus.req1  = r1;
        bus.code1 = CODE_W'(c1);
        bus.row1  = 4'(w1);

        win0 = 1'b0;
        win1 = 1'b0;
        if (r0 && r1) begin
            if (waited >= MAX_WAIT) win1 = 1'b1;
            else                    win0 = 1'b1;
        end else begin
            win0 = r0;
            win1 = r1;
        end
        if (win1 || !r1)               waited = 0;
        else if (waited < MAX_WAIT)    waited++;

        exp_g0 = win0;
        exp_g1 = win1;
        if (win0 || win1) begin
            code    = win1 ? c1 : c0;
            row     = win1 ? w1 : w0;
            e.owner = win1;
            e.err   = (code >= NUM_GLYPHS) || (row >= ROWS);
            e.bits  = e.err ? '0 : glyph_row(code, row);
            exp_ascii = e.err ? '0 : CODE_W'(code);
            sb_q.push_back(e);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    function automatic int unsigned rand_code();
        if ($urandom_range(0, 9) == 0) return $urandom_range(195, 210);
        return $urandom_range(0, NUM_GLYPHS - 1);
    endfunction

    function automatic int unsigned rand_row();
        if ($urandom_range(0, 7) == 0) return $urandom_range(8, 15);
        return $urandom_range(0, ROWS - 1);
    endfunction

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en && rst_n) begin
                check("gnt0", 32'(bus.gnt0), 32'(exp_g0));
                check("gnt1", 32'(bus.gnt1), 32'(exp_g1));
                check("gnt_excl", 32'(bus.gnt0 & bus.gnt1), 32'd0);
                check("rom_ascii", 32'(bus.rom_ascii), 32'(exp_ascii));
                if (bus.gnt0 === 1'b1) g0_seen++;
                if (bus.gnt1 === 1'b1) g1_seen++;
                if (bus.rd_valid !== 1'b0) begin
                    if (sb_q.size() == 0) begin
                        check("rd_unexpected", 32'(bus.rd_valid), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("rd_owner", 32'(bus.rd_owner), 32'(e.owner));
                        check("rd_err", 32'(bus.rd_err), 32'(e.err));
                        check("rd_bits", 32'(bus.rd_bits), 32'(e.bits));
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt0"},      32'(bus.gnt0),      32'd0);
        check({tag, "_gnt1"},      32'(bus.gnt1),      32'd0);
        check({tag, "_rom_ascii"}, 32'(bus.rom_ascii), 32'd0);
        check({tag, "_rd_valid"},  32'(bus.rd_valid),  32'd0);
        check({tag, "_rd_owner"},  32'(bus.rd_owner),  32'd0);
        check({tag, "_rd_bits"},   32'(bus.rd_bits),   32'd0);
        check({tag, "_rd_err"},    32'(bus.rd_err),    32'd0);
    endtask

    initial begin
        bit          p0;
        bit          p1;
        int unsigned c0;
        int unsigned w0;
        int unsigned c1;
        int unsigned w1;
        int unsigned s0;
        int unsigned s1;

        rst_n     = 1'b0;
        bus.req0  = 1'b0;
        bus.code0 = '0;
        bus.row0  = '0;
        bus.req1  = 1'b0;
        bus.code1 = '0;
        bus.row1  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Single lookup
        drive(1'b1, 65, 3, 1'b0, 0, 0);
        idle(3);

        // Back-to-back on port 1
        drive(1'b0, 0, 0, 1'b1, 10, 0);
        drive(1'b0, 0, 0, 1'b1, 11, 0);
        drive(1'b0, 0, 0, 1'b1, 12, 0);
        idle(3);

        // Starvation: both held for two full 5-cycle windows
        s0 = g0_seen;
        s1 = g1_seen;
        for (int unsigned i = 0; i < 10; i++) drive(1'b1, 66, 1, 1'b1, 67, 2);
        idle(3);
        check("starve_g0_count", g0_seen - s0, 32'd8);
        check("starve_g1_count", g1_seen - s1, 32'd2);

        // Range boundaries
        drive(1'b1, 200, 0, 1'b0, 0, 0);
        drive(1'b1, 199, 10, 1'b0, 0, 0);
        drive(1'b1, 199, 9, 1'b0, 0, 0);
        drive(1'b0, 0, 0, 1'b1, 0, 15);
        drive(1'b0, 0, 0, 1'b1, 0, 0);
        idle(3);

        // Randomised traffic with level requests held until granted
        p0 = 1'b0;
        p1 = 1'b0;
        c0 = 0; w0 = 0; c1 = 0; w1 = 0;
        for (int unsigned i = 0; i < 600; i++) begin
            if (exp_g0) p0 = 1'b0;
            if (exp_g1) p1 = 1'b0;
            if (p0 && $urandom_range(0, 9) == 0) p0 = 1'b0;
            else if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1'b1; c0 = rand_code(); w0 = rand_row();
            end
            if (p1 && $urandom_range(0, 11) == 0) p1 = 1'b0;
            else if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1'b1; c1 = rand_code(); w1 = rand_row();
            end
            drive(p0, c0, w0, p1, c1, w1);
        end

        // Reset mid-stream with a lookup in stage 1
        drive(1'b1, 70, 2, 1'b0, 0, 0);
        @(posedge clk);
        #3;
        check("pre_rst_gnt0", 32'(bus.gnt0), 32'd1);
        rst_n  = 1'b0;
        chk_en = 1'b0;
        #1;
        check_all_zero("midrst");
        sb_q.delete();
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        waited    = 0;
        exp_g0    = 1'b0;
        exp_g1    = 1'b0;
        exp_ascii = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(4);
        drive(1'b0, 0, 0, 1'b1, 199, 9);
        idle(4);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/font_rom_arbiter.md
# font_rom_arbiter

Shares the single combinational font glyph ROM (10×10 glyphs, 9-bit code, 200 entries) between two requesters: port 0 is the VGA text scan-out (priority) and port 1 is the secondary glyph consumer (PS/2 echo or cursor preview). The block arbitrates one lookup per cycle and registers the ROM address. It returns one selected 10-bit glyph row per grant, tagged with its owner, at a fixed 2-cycle latency. It sits between the text renderers and the font ROM instance in the VGA/PS2 top level.

## Interface
- `CODE_W`, default 9: glyph code width; drives ROM `ascii`.
- `NUM_GLYPHS`, default 200: valid codes are 0..NUM_GLYPHS-1.
- `ROWS`, default 10: glyph rows; row index 0..ROWS-1.
- `COLS`, default 10: bits per glyph row.
- `MAX_WAIT`, default 4: max consecutive port-0 grants while port 1 is pending.
- `clk` in 1: single clock; everything is rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0` in 1: port 0 lookup request, level; held until `gnt0`.
- `code0` in CODE_W: port 0 glyph code.
- `row0` in 4: port 0 row index.
- `req1`, `code1`, `row1`: same meaning for port 1.
- `gnt0`, `gnt1` out 1: registered grant, one-cycle pulse, mutually exclusive.
- `rom_ascii` out CODE_W: registered address to the font ROM.
- `rom_letra` in ROWS×COLS: ROM glyph, combinational from `rom_ascii`.
- `rd_valid` out 1: `rd_bits` is valid this cycle.
- `rd_owner` out 1: requester (0/1) that owns `rd_bits`.
- `rd_bits` out COLS: selected glyph row, MSB = leftmost pixel.
- `rd_err` out 1: with `rd_valid`, the code or row was out of range; `rd_bits` is forced to 0.

## Operation
- Arbitration happens every cycle. If only one `req` is high, that port wins.
- If both are high, port 0 wins unless `starve_cnt == MAX_WAIT`. In that case port 1 wins and `starve_cnt` clears.
- `starve_cnt` (3 bits) increments on each port-0 grant while `req1` is high. It clears on a port-1 grant or when `req1` is low. It saturates at MAX_WAIT.
- Winner's code and row are captured into stage-1 registers: `rom_ascii`, `row_s1`, `own_s1`, `err_s1`, `v_s1`. The matching `gnt` pulses in the same cycle the capture is visible.
- `err_s1` is set if code ≥ NUM_GLYPHS or row ≥ ROWS. On error, `rom_ascii` is driven 0 so the ROM is never addressed out of range.
- Stage 2 registers `rd_bits = err_s1 ? 0 : rom_letra[row_s1]`, together with `rd_owner`, `rd_err` and `rd_valid = v_s1`.
- Throughput is one lookup per cycle, back-to-back, with no bubbles.
- A requester sees `gnt` and may change `code`/`row` or drop `req` in the next cycle.
- A request dropped before its grant is lost silently. No state is kept for it.

## Timing
- Request sampled at edge N. At edge N:
  - `gnt` goes high.
  - `rom_ascii` takes the code.
- At edge N+1:
  - `rd_valid` goes high.
  - `rd_bits` is valid.
- Latency from grant to data is 1 cycle; from request sample to data is 2 edges.
- Reset (`rst_n` low, any time) asynchronously forces:
  - `gnt0 = gnt1 = 0`
  - `rom_ascii = 0`
  - `rd_valid = 0`, `rd_owner = 0`, `rd_bits = 0`, `rd_err = 0`
  - `starve_cnt = 0`, all stage valids 0
- In-flight lookups are discarded at reset. The first grant can occur at the first edge after `rst_n` rises.
- Boundary cases:
  - Code NUM_GLYPHS-1 with row ROWS-1 is legal.
  - Code NUM_GLYPHS or row ROWS sets `rd_err`.
  - `starve_cnt` never exceeds MAX_WAIT.
  - When both requesters are idle, `rom_ascii` holds its last value and `rd_valid` is 0.

## Test plan
- Reset mid-stream: assert `rst_n = 0` while `v_s1 = 1` → all outputs read 0 immediately. No `rd_valid` follows after release until a new request arrives.
- Single lookup: `req0`, code 65, row 3 → `gnt0` at edge N, `rom_ascii = 65`. At N+1: `rd_valid = 1`, `rd_owner = 0`, `rd_bits` equals ROM row 3 of glyph 65.
- Back-to-back: `req1` held high with codes 10, 11, 12 (row 0) over 3 cycles → three consecutive `gnt1` pulses, then three consecutive `rd_valid` beats in order with owner 1.
- Starvation: `req0` and `req1` held high continuously → 4 `gnt0` pulses, then 1 `gnt1`, repeating in a 5-cycle pattern. `gnt0` and `gnt1` are never high in the same cycle.
- Range errors: code 200 row 0 → `rd_err = 1`, `rd_bits = 0`, `rom_ascii = 0`. Code 199 row 10 → `rd_err = 1`. Code 199 row 9 → `rd_err = 0`.
